// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM driver: FSM states, 100 MHz default
// timing constants and the pulse-width arithmetic helpers.
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } servo_state_t;

    // Defaults for a 100 MHz system clock driving a standard 50 Hz servo.
    localparam int unsigned DEF_W            = 32;
    localparam int unsigned DEF_FRAME_CYCLES = 2000000;  // 20 ms
    localparam int unsigned DEF_PW_MIN       = 50000;    // 0.5 ms
    localparam int unsigned DEF_PW_MAX       = 250000;   // 2.5 ms
    localparam int unsigned DEF_PW_RESET     = 150000;   // centre
    localparam int unsigned DEF_STEP         = 1000;     // per-frame slew

    // Force a requested pulse width into the legal window [lo, hi].
    // Done at 64 bits so any W up to 64 can share one helper.
    function automatic logic [63:0] clamp_pw(
        input logic [63:0] v,
        input logic [63:0] lo,
        input logic [63:0] hi
    );
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Move cur toward tgt by at most step. The difference is always taken
    // larger-minus-smaller, so unsigned subtraction never wraps.
    function automatic logic [63:0] step_toward(
        input logic [63:0] cur,
        input logic [63:0] tgt,
        input logic [63:0] step
    );
        if (tgt >= cur) begin
            if (tgt - cur <= step)
                return tgt;
            else
                return cur + step;
        end else begin
            if (cur - tgt <= step)
                return tgt;
            else
                return cur - step;
        end
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame position counter for the servo PWM. Counts 0..FRAME_CYCLES-1 while
// run is high and is parked at 0 otherwise. frame_tick marks the last cycle
// of every running frame.
module servo_frame_timer #(
    parameter int unsigned W            = 32,
    parameter int unsigned FRAME_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    output logic [W-1:0] cnt,
    output logic         frame_tick
);

    localparam logic [W-1:0] LAST = W'(FRAME_CYCLES - 1);

    // Combinational so the tick lines up with the cycle where cnt is LAST;
    // it is low in reset because cnt is held at 0 there.
    assign frame_tick = run && (cnt == LAST);

    // Count while running, wrap at the frame end, hold at 0 when stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!run || frame_tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/servo_pwm_driver.sv
// One-axis servo PWM driver: accepts clamped pulse-width targets over a
// valid/ready handshake, slews the active width toward the target once per
// frame and emits a registered 50 Hz PWM waveform on SERVO.
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int unsigned W            = DEF_W,
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int unsigned PW_MIN       = DEF_PW_MIN,
    parameter int unsigned PW_MAX       = DEF_PW_MAX,
    parameter int unsigned PW_RESET     = DEF_PW_RESET,
    parameter int unsigned STEP         = DEF_STEP
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         EN,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_pw,
    output logic         SERVO,
    output logic [W-1:0] pw_current,
    output logic         at_target,
    output logic         limit_hit,
    output logic         frame_tick
);

    localparam logic [W-1:0] PW_RESET_W = W'(PW_RESET);

    servo_state_t state;
    logic [W-1:0] target;
    logic [W-1:0] cnt;
    logic [W-1:0] cmd_clamped;
    logic [W-1:0] pw_next;
    logic         accept;
    logic         running;

    // Ready simply mirrors reset: there is no queue, a new command just
    // overwrites the target, so the driver can always take one.
    assign cmd_ready   = RST_N;
    assign accept      = cmd_valid && cmd_ready;
    assign running     = (state != IDLE);
    assign cmd_clamped = W'(clamp_pw(64'(cmd_pw), 64'(PW_MIN), 64'(PW_MAX)));
    assign pw_next     = W'(step_toward(64'(pw_current), 64'(target), 64'(STEP)));

    servo_frame_timer #(
        .W            (W),
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_timer (
        .clk        (CLK),
        .rst_n      (RST_N),
        .run        (running),
        .cnt        (cnt),
        .frame_tick (frame_tick)
    );

    // Run/stop sequencing plus the registered PWM pin. SERVO is high for
    // cnt in [0, pw_current), seen one cycle later, so the pulse spans
    // exactly pw_current cycles starting the cycle after cnt==0. A stop
    // request never cuts a frame short; a frame end with EN low always
    // parks the driver, whether or not STOPPING was visited first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            SERVO <= 1'b0;
        end else begin
            SERVO <= running && (cnt < pw_current);
            case (state)
                IDLE: begin
                    if (EN)
                        state <= RUN;
                end
                RUN: begin
                    if (!EN && frame_tick)
                        state <= IDLE;
                    else if (!EN)
                        state <= STOPPING;
                end
                STOPPING: begin
                    if (EN)
                        state <= RUN;
                    else if (frame_tick)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Target capture, per-frame slew and status flags. Both the accept and
    // the frame-end update use pre-edge values, so a command landing on the
    // frame-end cycle only influences the following frame end.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            target     <= PW_RESET_W;
            pw_current <= PW_RESET_W;
            at_target  <= 1'b1;
            limit_hit  <= 1'b0;
        end else begin
            limit_hit <= accept && (cmd_clamped != cmd_pw);
            if (accept)
                target <= cmd_clamped;
            if (frame_tick)
                pw_current <= pw_next;
            at_target <= (pw_current == target);
        end
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Self-checking bench for servo_pwm_driver: a frame-level reference model
// predicts each frame's pulse width and tick time plus every limit_hit
// response; a monitor compares what the DUT presents against the queues.
module tb_servo_pwm_driver;

    localparam int FR   = 100;
    localparam int PMIN = 10;
    localparam int PMAX = 40;
    localparam int PRST = 25;
    localparam int STP  = 5;
    localparam int W    = 32;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         EN = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [W-1:0] cmd_pw = '0;
    logic         cmd_ready;
    logic         SERVO;
    logic [W-1:0] pw_current;
    logic         at_target;
    logic         limit_hit;
    logic         frame_tick;

    int total = 0;
    int bad = 0;

    servo_pwm_driver #(
        .W            (W),
        .FRAME_CYCLES (FR),
        .PW_MIN       (PMIN),
        .PW_MAX       (PMAX),
        .PW_RESET     (PRST),
        .STEP         (STP)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_pw     (cmd_pw),
        .SERVO      (SERVO),
        .pw_current (pw_current),
        .at_target  (at_target),
        .limit_hit  (limit_hit),
        .frame_tick (frame_tick)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(string name, longint got, longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int     width;
        bit     at;
        longint stamp;
    } frame_rec_t;

    typedef struct {
        bit     hit;
        longint stamp;
    } lim_rec_t;

    frame_rec_t frame_q[$];
    lim_rec_t   lim_q[$];

    bit m_run = 1'b0;
    int m_pos = 0;
    int m_pw  = PRST;
    int m_tgt = PRST;
    bit m_at  = 1'b1;

    function automatic int clampi(int v);
        if (v < PMIN) return PMIN;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    function automatic int ramp(int pw, int tgt);
        int d;
        d = tgt - pw;
        if (d >= -STP && d <= STP) return tgt;
        return (d > 0) ? pw + STP : pw - STP;
    endfunction

    // Behavioural model advanced once per clock; it queues the expected
    // outcome of each frame when that frame's last cycle begins.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_run = 1'b0;
            m_pos = 0;
            m_pw  = PRST;
            m_tgt = PRST;
            m_at  = 1'b1;
            frame_q.delete();
            lim_q.delete();
        end else begin
            int raw;
            int new_tgt;
            raw     = int'(cmd_pw);
            m_at    = (m_pw == m_tgt);
            new_tgt = m_tgt;
            if (cmd_valid) begin
                new_tgt = clampi(raw);
                lim_q.push_back('{hit: (new_tgt != raw), stamp: longint'($time) + 5});
            end
            if (!m_run) begin
                m_run = EN;
                m_pos = 0;
            end else if (m_pos == FR - 1) begin
                m_pw  = ramp(m_pw, m_tgt);
                m_pos = 0;
                m_run = EN;
            end else begin
                m_pos++;
            end
            m_tgt = new_tgt;
            if (m_run && m_pos == FR - 1)
                frame_q.push_back('{width: m_pw, at: m_at, stamp: longint'($time) + 5});
        end
    end

    // ---------------- monitor ----------------
    int         hi_cnt = 0;
    frame_rec_t fr;
    lim_rec_t   lr;

    always @(negedge CLK) begin
        if (!RST_N) begin
            hi_cnt = 0;
        end else begin
            if (lim_q.size() > 0 && lim_q[0].stamp == longint'($time)) begin
                lr = lim_q.pop_front();
                chk("limit_hit", longint'(limit_hit), longint'(lr.hit));
            end else if (limit_hit) begin
                chk("limit_hit_spurious", longint'(limit_hit), longint'(0));
            end
            if (frame_tick) begin
                if (frame_q.size() == 0) begin
                    chk("frame_tick_unexpected", longint'(frame_tick), longint'(0));
                end else begin
                    fr = frame_q.pop_front();
                    chk("tick_time", longint'($time), fr.stamp);
                    chk("servo_width", longint'(hi_cnt), longint'(fr.width));
                    chk("pw_current", longint'(pw_current), longint'(fr.width));
                    chk("at_target", longint'(at_target), longint'(fr.at));
                end
                hi_cnt = 0;
            end else if (frame_q.size() > 0 && longint'($time) > frame_q[0].stamp) begin
                chk("frame_tick_missing", longint'(frame_tick), longint'(1));
                void'(frame_q.pop_front());
            end
            if (SERVO)
                hi_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send(input int v);
        cmd_pw    = v;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (!frame_tick && n < FR + 10) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_tick_timeout", longint'(frame_tick), longint'(1));
    endtask

    initial begin
        int n;

        // Reset state
        cycles(3);
        chk("rst_servo", longint'(SERVO), longint'(0));
        chk("rst_pw_current", longint'(pw_current), longint'(PRST));
        chk("rst_at_target", longint'(at_target), longint'(1));
        chk("rst_limit_hit", longint'(limit_hit), longint'(0));
        chk("rst_frame_tick", longint'(frame_tick), longint'(0));
        chk("rst_cmd_ready", longint'(cmd_ready), longint'(0));
        RST_N = 1'b1;
        #1;
        chk("cmd_ready_after_reset", longint'(cmd_ready), longint'(1));
        cycles(3);
        chk("idle_servo_low", longint'(SERVO), longint'(0));

        // Steady centre position
        EN = 1'b1;
        cycles(350);

        // Ramp up to 40 from a mid-frame command
        wait_tick();
        cycles(40);
        send(40);
        cycles(450);

        // Clamped commands, then ramp down to 10
        send(55);
        cycles(20);
        send(3);
        cycles(800);

        // Command accepted on the frame-end cycle
        wait_tick();
        cmd_pw    = 30;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cycles(250);

        // Stop request early in a frame: pulse and frame complete, then idle
        wait_tick();
        cycles(11);
        EN = 1'b0;
        cycles(300);
        chk("stopped_servo_low", longint'(SERVO), longint'(0));

        // Restart, then drop and re-raise EN within one frame
        EN = 1'b1;
        cycles(150);
        wait_tick();
        cycles(11);
        EN = 1'b0;
        cycles(40);
        EN = 1'b1;
        cycles(250);

        // Randomized commands and enable toggling
        repeat (4000) begin
            @(negedge CLK);
            if ($urandom_range(0, 199) == 0)
                EN = ~EN;
            cmd_valid = ($urandom_range(0, 9) == 0);
            cmd_pw    = $urandom_range(0, 60);
        end
        cmd_valid = 1'b0;
        EN = 1'b1;
        cycles(150);

        // Asynchronous reset in the middle of a pulse
        n = 0;
        while (!SERVO && n < 3 * FR) begin
            @(negedge CLK);
            n++;
        end
        chk("servo_high_before_reset", longint'(SERVO), longint'(1));
        #2 RST_N = 1'b0;
        #1;
        chk("servo_async_reset", longint'(SERVO), longint'(0));
        chk("cmd_ready_in_reset", longint'(cmd_ready), longint'(0));
        EN = 1'b0;
        cycles(2);
        RST_N = 1'b1;
        #1;
        chk("post_reset_pw", longint'(pw_current), longint'(PRST));
        chk("post_reset_at_target", longint'(at_target), longint'(1));
        cycles(5);
        chk("post_reset_idle", longint'(SERVO), longint'(0));

        // Target must be back at the centre value: widths stay at 25
        EN = 1'b1;
        cycles(250);
        EN = 1'b0;
        cycles(250);
        chk("frames_drained", longint'(frame_q.size()), longint'(0));
        chk("limits_drained", longint'(lim_q.size()), longint'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
